// File: rtl/q_frag_cfg_pkg.sv
// ----------------------------------------------------------------------------
// q_frag_cfg_pkg
// Shared definitions for the q_frag_cfg logic-cell output stage:
//   - state_t          : configuration loader FSM states
//   - CFG_BITS_DEFAULT : default width of the mux-fragment inverter config word
//   - frame_len()      : serial frame length for a given config width
// Build option: define Q_FRAG_CFG_PARITY_EN to append one even-parity bit to
// every serial frame.
// ----------------------------------------------------------------------------
package q_frag_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int CFG_BITS_DEFAULT = 4;

    // Serial frame length: the config word, plus a trailing parity bit when
    // parity checking is built in.
    function automatic int frame_len(input int cfg_bits);
`ifdef Q_FRAG_CFG_PARITY_EN
        return cfg_bits + 1;
`else
        return cfg_bits;
`endif
    endfunction

endpackage

// File: rtl/q_frag_cfg_shift.sv
// ----------------------------------------------------------------------------
// q_frag_cfg_shift
// Shadow shift register and bit counter for the serial configuration frame.
// Bits enter at the LSB and move up, so the first bit sent ends in the MSB.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   shift_en in   shift si in and count it
//   clear    in   drop the shadow contents and zero the counter (wins over shift_en)
//   si       in   serial bit
//   shadow   out  FRAME-bit shadow register
//   last     out  the next accepted bit completes the frame
// ----------------------------------------------------------------------------
module q_frag_cfg_shift #(
    parameter int FRAME = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             si,
    output logic [FRAME-1:0] shadow,
    output logic             last
);

    localparam int CNT_W = $clog2(FRAME + 1);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours; = here would chain the shift.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shadow <= '0;
            count  <= '0;
        end else if (shift_en) begin
            // Shift form rather than a slice so FRAME == 1 stays legal.
            shadow <= (shadow << 1) | FRAME'(si);
            count  <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(FRAME - 1));

endmodule

// File: rtl/q_frag_cfg.sv
// ----------------------------------------------------------------------------
// q_frag_cfg
// Registered output stage of a logic cell with a serially loaded
// configuration word for the upstream mux fragment inverters
// (CFG_Q bit0=XAS1, bit1=XAS2, bit2=XBS1, bit3=XBS2).
// Ports:
//   QCK       in   sole clock, rising edge
//   QRT       in   synchronous active-high reset
//   CZ        in   logic result from the upstream mux stage
//   QDI       in   direct data bypassing the logic
//   QDS       in   data select: 1 = QDI, 0 = CZ
//   QEN       in   capture enable
//   QST       in   synchronous set
//   CFG_SI    in   serial configuration bit (MSB first)
//   CFG_VALID in   CFG_SI is valid
//   CFG_READY out  a serial bit is accepted this cycle when CFG_VALID is high
//   CFG_LOAD  in   commit request
//   CFG_DONE  out  one-cycle pulse when a commit takes effect
//   CFG_ERR   out  one-cycle pulse when a commit is rejected
//   CFG_Q     out  active configuration word
//   QZ        out  registered cell output
// Build option: Q_FRAG_CFG_PARITY_EN adds a trailing even-parity bit to the
// frame; a frame with odd overall parity is rejected at CFG_LOAD.
// ----------------------------------------------------------------------------
module q_frag_cfg
    import q_frag_cfg_pkg::*;
#(
    parameter int                CFG_BITS = CFG_BITS_DEFAULT,
    parameter logic              QZ_INIT  = 1'b0,
    parameter logic [CFG_BITS-1:0] CFG_INIT = '0
) (
    input  logic                QCK,
    input  logic                QRT,
    input  logic                CZ,
    input  logic                QDI,
    input  logic                QDS,
    input  logic                QEN,
    input  logic                QST,
    input  logic                CFG_SI,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    input  logic                CFG_LOAD,
    output logic                CFG_DONE,
    output logic                CFG_ERR,
    output logic [CFG_BITS-1:0] CFG_Q,
    output logic                QZ
);

    localparam int FRAME = frame_len(CFG_BITS);

    state_t           state, state_next;
    logic [FRAME-1:0] shadow;
    logic             last;
    logic             shift_en;
    logic             clear;
    logic             parity_bad;
    logic             done_raw;
    logic             err_raw;

    // ------------------------------------------------------------------
    // Data register: reset, then set, then enabled capture, else hold.
    // ------------------------------------------------------------------
    always_ff @(posedge QCK) begin
        if (QRT) begin
            QZ <= QZ_INIT;
        end else if (QST) begin
            QZ <= 1'b1;
        end else if (QEN) begin
            QZ <= QDS ? QDI : CZ;
        end
    end

    // ------------------------------------------------------------------
    // Serial shadow register and bit counter.
    // ------------------------------------------------------------------
    q_frag_cfg_shift #(
        .FRAME (FRAME)
    ) u_shift (
        .clk      (QCK),
        .rst      (QRT),
        .shift_en (shift_en),
        .clear    (clear),
        .si       (CFG_SI),
        .shadow   (shadow),
        .last     (last)
    );

`ifdef Q_FRAG_CFG_PARITY_EN
    // Data plus parity bit must hold an even number of ones.
    assign parity_bad = ^shadow;
`else
    assign parity_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Loader FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        CFG_READY  = 1'b0;
        shift_en   = 1'b0;
        clear      = 1'b0;
        done_raw   = 1'b0;
        err_raw    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // CFG_LOAD is ignored here: nothing to commit or reject.
                CFG_READY = 1'b1;
                if (CFG_VALID) begin
                    shift_en   = 1'b1;
                    state_next = last ? ST_FULL : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                CFG_READY = 1'b1;
                // A partial-frame commit wins over a coincident bit.
                if (CFG_LOAD) begin
                    clear      = 1'b1;
                    err_raw    = 1'b1;
                    state_next = ST_IDLE;
                end else if (CFG_VALID) begin
                    shift_en = 1'b1;
                    if (last) begin
                        state_next = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (CFG_LOAD) begin
                    if (parity_bad) begin
                        clear      = 1'b1;
                        err_raw    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                done_raw   = 1'b1;
                clear      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A reset arriving in the same cycle aborts the commit or rejection, so
    // neither pulse may escape.
    assign CFG_DONE = done_raw & ~QRT;
    assign CFG_ERR  = err_raw  & ~QRT;

    // Active configuration word: only the COMMIT state writes it.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            CFG_Q <= CFG_INIT;
        end else if (state == ST_COMMIT) begin
            CFG_Q <= shadow[FRAME-1 -: CFG_BITS];
        end
    end

endmodule

// File: tb/tb_q_frag_cfg.sv
// ----------------------------------------------------------------------------
// tb_q_frag_cfg
// Directed bench for q_frag_cfg with default parameters (CFG_BITS=4,
// QZ_INIT=0, CFG_INIT=0). Inputs change 1 ns after a rising edge; outputs
// are read 1 ns after inputs settle or 1 ns after an edge.
// Build option: Q_FRAG_CFG_PARITY_EN selects the parity-frame scenarios.
// ----------------------------------------------------------------------------
module tb_q_frag_cfg;

    logic       QCK = 1'b0;
    logic       QRT, CZ, QDI, QDS, QEN, QST;
    logic       CFG_SI, CFG_VALID, CFG_LOAD;
    logic       CFG_READY, CFG_DONE, CFG_ERR, QZ;
    logic [3:0] CFG_Q;

    int checks   = 0;
    int failures = 0;

    q_frag_cfg dut (
        .QCK       (QCK),
        .QRT       (QRT),
        .CZ        (CZ),
        .QDI       (QDI),
        .QDS       (QDS),
        .QEN       (QEN),
        .QST       (QST),
        .CFG_SI    (CFG_SI),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_LOAD  (CFG_LOAD),
        .CFG_DONE  (CFG_DONE),
        .CFG_ERR   (CFG_ERR),
        .CFG_Q     (CFG_Q),
        .QZ        (QZ)
    );

    always #5 QCK = ~QCK;

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        CFG_SI    = b;
        CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
    endtask

    // Sends a complete frame MSB first; parity builds append the even-parity bit.
    task automatic send_frame(input logic [3:0] data);
        for (int i = 3; i >= 0; i--) send_bit(data[i]);
`ifdef Q_FRAG_CFG_PARITY_EN
        send_bit(^data);
`endif
    endtask

    // Pulses CFG_LOAD from FULL and checks the two-cycle commit timing.
    task automatic commit_frame(input string name, input logic [3:0] old_q,
                                input logic [3:0] new_q);
        CFG_LOAD = 1'b1;
        #1;
        checks++;
        if (CFG_ERR !== 1'b0) begin
            failures++;
            $display("FAIL %s_no_err: CFG_ERR=%b want 0", name, CFG_ERR);
        end
        tick();
        CFG_LOAD = 1'b0;
        #1;
        checks++;
        if (CFG_DONE !== 1'b1 || CFG_Q !== old_q) begin
            failures++;
            $display("FAIL %s_commit_cycle: CFG_DONE=%b CFG_Q=%b want 1 %b", name, CFG_DONE, CFG_Q, old_q);
        end
        tick();
        checks++;
        if (CFG_DONE !== 1'b0 || CFG_Q !== new_q || CFG_READY !== 1'b1) begin
            failures++;
            $display("FAIL %s_after_commit: CFG_DONE=%b CFG_Q=%b CFG_READY=%b want 0 %b 1",
                     name, CFG_DONE, CFG_Q, CFG_READY, new_q);
        end
    endtask

    task automatic test_reset();
        QRT = 1'b1;
        tick();
        checks++;
        if (QZ !== 1'b0 || CFG_Q !== 4'b0000 || CFG_READY !== 1'b1 ||
            CFG_DONE !== 1'b0 || CFG_ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset: QZ=%b CFG_Q=%b RDY=%b DONE=%b ERR=%b want 0 0000 1 0 0",
                     QZ, CFG_Q, CFG_READY, CFG_DONE, CFG_ERR);
        end
        QRT = 1'b0;
    endtask

    task automatic test_capture();
        QEN = 1'b1; QDS = 1'b0; CZ = 1'b1;
        tick();
        checks++;
        if (QZ !== 1'b1) begin
            failures++;
            $display("FAIL capture_cz: QZ=%b want 1", QZ);
        end
        QEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            CZ = ~CZ;
            tick();
            checks++;
            if (QZ !== 1'b1) begin
                failures++;
                $display("FAIL hold_%0d: QZ=%b want 1", i, QZ);
            end
        end
        // Bypass path: QDI selected while CZ disagrees.
        QEN = 1'b1; QDS = 1'b1; QDI = 1'b0; CZ = 1'b1;
        #1;
        checks++;
        if (QZ !== 1'b1) begin
            failures++;
            $display("FAIL no_comb_path: QZ=%b want 1", QZ);
        end
        tick();
        checks++;
        if (QZ !== 1'b0) begin
            failures++;
            $display("FAIL capture_qdi: QZ=%b want 0", QZ);
        end
        QDS = 1'b0; CZ = 1'b1;
        tick();
        checks++;
        if (QZ !== 1'b1) begin
            failures++;
            $display("FAIL capture_cz_again: QZ=%b want 1", QZ);
        end
        QEN = 1'b0;
    endtask

    task automatic test_priority();
        QRT = 1'b1; QST = 1'b1; QEN = 1'b1; CZ = 1'b1;
        tick();
        checks++;
        if (QZ !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_set: QZ=%b want 0", QZ);
        end
        QRT = 1'b0; QST = 1'b1; QEN = 1'b1; CZ = 1'b0;
        tick();
        checks++;
        if (QZ !== 1'b1) begin
            failures++;
            $display("FAIL set_over_en: QZ=%b want 1", QZ);
        end
        QST = 1'b0;
        tick();
        checks++;
        if (QZ !== 1'b0) begin
            failures++;
            $display("FAIL en_after_set: QZ=%b want 0", QZ);
        end
        QST = 1'b1; QEN = 1'b0;
        tick();
        checks++;
        if (QZ !== 1'b1) begin
            failures++;
            $display("FAIL set_no_en: QZ=%b want 1", QZ);
        end
        QST = 1'b0;
    endtask

    task automatic test_commit();
        send_frame(4'b1011);
        checks++;
        if (CFG_READY !== 1'b0) begin
            failures++;
            $display("FAIL full_not_ready: CFG_READY=%b want 0", CFG_READY);
        end
        // Data register keeps working while the loader sits in FULL.
        QEN = 1'b1; CZ = 1'b0;
        tick();
        QEN = 1'b0;
        checks++;
        if (QZ !== 1'b0 || CFG_READY !== 1'b0) begin
            failures++;
            $display("FAIL full_holds: QZ=%b CFG_READY=%b want 0 0", QZ, CFG_READY);
        end
        commit_frame("commit1011", 4'b0000, 4'b1011);
    endtask

    task automatic test_partial();
        send_bit(1'b0);
        send_bit(1'b1);
        CFG_LOAD = 1'b1;
        #1;
        checks++;
        if (CFG_ERR !== 1'b1 || CFG_DONE !== 1'b0) begin
            failures++;
            $display("FAIL partial_err: CFG_ERR=%b CFG_DONE=%b want 1 0", CFG_ERR, CFG_DONE);
        end
        tick();
        CFG_LOAD = 1'b0;
        #1;
        checks++;
        if (CFG_ERR !== 1'b0 || CFG_READY !== 1'b1 || CFG_Q !== 4'b1011) begin
            failures++;
            $display("FAIL partial_after: CFG_ERR=%b CFG_READY=%b CFG_Q=%b want 0 1 1011",
                     CFG_ERR, CFG_READY, CFG_Q);
        end
        // Counter must have restarted: a full new frame commits cleanly.
        send_frame(4'b0110);
        commit_frame("after_partial", 4'b1011, 4'b0110);
    endtask

    task automatic test_load_idle();
        CFG_LOAD = 1'b1;
        #1;
        checks++;
        if (CFG_ERR !== 1'b0 || CFG_DONE !== 1'b0) begin
            failures++;
            $display("FAIL idle_load: CFG_ERR=%b CFG_DONE=%b want 0 0", CFG_ERR, CFG_DONE);
        end
        tick();
        CFG_LOAD = 1'b0;
        #1;
        checks++;
        if (CFG_DONE !== 1'b0 || CFG_ERR !== 1'b0 || CFG_READY !== 1'b1 || CFG_Q !== 4'b0110) begin
            failures++;
            $display("FAIL idle_load_after: DONE=%b ERR=%b RDY=%b CFG_Q=%b want 0 0 1 0110",
                     CFG_DONE, CFG_ERR, CFG_READY, CFG_Q);
        end
    endtask

    task automatic test_coincide();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        CFG_SI = 1'b1; CFG_VALID = 1'b1; CFG_LOAD = 1'b1;
        #1;
        checks++;
        if (CFG_ERR !== 1'b1) begin
            failures++;
            $display("FAIL coincide_err: CFG_ERR=%b want 1", CFG_ERR);
        end
        tick();
        CFG_VALID = 1'b0; CFG_LOAD = 1'b0;
        send_frame(4'b1001);
        commit_frame("after_coincide", 4'b0110, 4'b1001);
    endtask

    task automatic test_abort();
        int dones;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        QRT = 1'b1;
        tick();
        QRT = 1'b0;
        checks++;
        if (CFG_Q !== 4'b0000 || CFG_READY !== 1'b1) begin
            failures++;
            $display("FAIL abort_reset: CFG_Q=%b CFG_READY=%b want 0000 1", CFG_Q, CFG_READY);
        end
        send_frame(4'b0101);
        CFG_LOAD = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            CFG_LOAD = 1'b0;
            if (CFG_DONE === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || CFG_Q !== 4'b0101) begin
            failures++;
            $display("FAIL abort_second_frame: dones=%0d CFG_Q=%b want 1 0101", dones, CFG_Q);
        end
        // Reset landing in COMMIT: no pulse and no commit.
        send_frame(4'b1100);
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        QRT = 1'b1;
        #1;
        checks++;
        if (CFG_DONE !== 1'b0) begin
            failures++;
            $display("FAIL commit_reset_pulse: CFG_DONE=%b want 0", CFG_DONE);
        end
        tick();
        QRT = 1'b0;
        #1;
        checks++;
        if (CFG_Q !== 4'b0000 || CFG_DONE !== 1'b0) begin
            failures++;
            $display("FAIL commit_reset_after: CFG_Q=%b CFG_DONE=%b want 0000 0", CFG_Q, CFG_DONE);
        end
    endtask

`ifdef Q_FRAG_CFG_PARITY_EN
    task automatic test_parity();
        // 1,0,1,1 with parity 0: odd overall, rejected.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        CFG_LOAD = 1'b1;
        #1;
        checks++;
        if (CFG_ERR !== 1'b1) begin
            failures++;
            $display("FAIL parity_bad_err: CFG_ERR=%b want 1", CFG_ERR);
        end
        tick();
        CFG_LOAD = 1'b0;
        #1;
        checks++;
        if (CFG_Q !== 4'b0000 || CFG_DONE !== 1'b0 || CFG_READY !== 1'b1) begin
            failures++;
            $display("FAIL parity_bad_after: CFG_Q=%b DONE=%b RDY=%b want 0000 0 1",
                     CFG_Q, CFG_DONE, CFG_READY);
        end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        commit_frame("parity_good", 4'b0000, 4'b1011);
    endtask
`else
    task automatic test_frame_len();
        // Four bits fill the frame: the fourth bit drops CFG_READY.
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (CFG_READY !== 1'b1) begin
            failures++;
            $display("FAIL frame_three_ready: CFG_READY=%b want 1", CFG_READY);
        end
        send_bit(1'b1);
        checks++;
        if (CFG_READY !== 1'b0) begin
            failures++;
            $display("FAIL frame_four_full: CFG_READY=%b want 0", CFG_READY);
        end
        commit_frame("frame_0011", 4'b0000, 4'b0011);
    endtask
`endif

    initial begin
        QRT = 1'b1; CZ = 1'b0; QDI = 1'b0; QDS = 1'b0; QEN = 1'b0; QST = 1'b0;
        CFG_SI = 1'b0; CFG_VALID = 1'b0; CFG_LOAD = 1'b0;
        tick();
        tick();
        QRT = 1'b0;
        test_reset();
        test_capture();
        test_priority();
        test_commit();
        test_partial();
        test_load_idle();
        test_coincide();
        test_abort();
`ifdef Q_FRAG_CFG_PARITY_EN
        test_parity();
`else
        test_frame_len();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
